byte_decode: RTL and testbench

//  ByteDecode_l for the Kyber decrypt/decaps path: inverse of the encode stage. Takes 64-bit packed words

---
 rtl/kyber_pkg.sv | 38 +++
 rtl/bit_unpacker.sv | 58 +++++
 rtl/byte_decode.sv | 125 ++++++++++++
 tb/tb_byte_decode.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, supported coefficient widths and the encode/decode FSM encoding.
package kyber_pkg;

  localparam int unsigned KYBER_N       = 256;
  localparam int unsigned KYBER_Q       = 3329;
  localparam int unsigned KYBER_COEFF_W = 12;
  localparam int unsigned KYBER_L_W     = 4;

  localparam logic [KYBER_L_W-1:0] L_1  = 4'd1;
  localparam logic [KYBER_L_W-1:0] L_4  = 4'd4;
  localparam logic [KYBER_L_W-1:0] L_5  = 4'd5;
  localparam logic [KYBER_L_W-1:0] L_10 = 4'd10;
  localparam logic [KYBER_L_W-1:0] L_11 = 4'd11;
  localparam logic [KYBER_L_W-1:0] L_12 = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } kyber_state_e;

  // Anything outside the supported set is treated as the full 12-bit width.
  function automatic logic [KYBER_L_W-1:0] sanitize_l(input logic [KYBER_L_W-1:0] l);
    logic [KYBER_L_W-1:0] r;
    case (l)
      L_1, L_4, L_5, L_10, L_11, L_12: r = l;
      default:                         r = L_12;
    endcase
    return r;
  endfunction

  function automatic logic [KYBER_COEFF_W-1:0] l_mask(input logic [KYBER_L_W-1:0] l);
    logic [KYBER_COEFF_W:0] m;
    m = (13'd1 << l) - 13'd1;
    return m[KYBER_COEFF_W-1:0];
  endfunction

endpackage

// File: rtl/bit_unpacker.sv
// LSB-first bit buffer: words are appended above the live bits, coefficient pairs are
// consumed from the bottom. Push and pop may happen in the same cycle.
module bit_unpacker
  import kyber_pkg::*;
#(
  parameter int unsigned WORD_W  = 64,
  parameter int unsigned BUF_W   = 88,
  parameter int unsigned FILL_W  = 7,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [WORD_W-1:0]          i_word,
  input  logic                       i_pop,
  input  logic [SHIFT_W-1:0]         i_pop_bits,
  output logic [FILL_W-1:0]          o_fill,
  output logic [2*KYBER_COEFF_W-1:0] o_bits
);

  logic [BUF_W-1:0]  buf_q, buf_d, shifted;
  logic [FILL_W-1:0] fill_q, fill_d, offset;

  always_comb begin
    shifted = buf_q;
    offset  = fill_q;
    if (i_pop) begin
      shifted = buf_q >> i_pop_bits;
      offset  = fill_q - FILL_W'(i_pop_bits);
    end
    buf_d  = shifted;
    fill_d = offset;
    // Bits above fill are always zero, so OR-ing the new word in is sufficient.
    if (i_push) begin
      buf_d  = shifted | (BUF_W'(i_word) << offset);
      fill_d = offset + FILL_W'(WORD_W);
    end
    if (i_clear) begin
      buf_d  = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

  assign o_fill = fill_q;
  assign o_bits = buf_q[2*KYBER_COEFF_W-1:0];

endmodule

// File: rtl/byte_decode.sv
// ByteDecode_l: unpacks 64-bit words into 256 l-bit coefficients, two per beat.
// Optional DECODE_MODQ_EN reduces l=12 coefficients >= q by one subtraction of q.
module byte_decode
  import kyber_pkg::*;
#(
  parameter int unsigned WORD_W  = 64,
  parameter int unsigned COEFF_W = 12,
  parameter int unsigned BUF_W   = 88
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_start,
  input  logic [3:0]           i_l,
  input  logic [WORD_W-1:0]    i_ibytes,
  input  logic                 i_ibytes_valid,
  output logic                 o_ibytes_ready,
  output logic [2*COEFF_W-1:0] o_coeffs,
  output logic                 o_coeffs_valid,
  input  logic                 i_coeffs_ready,
  output logic                 o_done
);

  localparam int unsigned FillW = 7;

  kyber_state_e state_q, state_d;

  logic [3:0]           l_q;
  logic [5:0]           words_q;
  logic [7:0]           pairs_q;
  logic                 valid_q;
  logic [2*COEFF_W-1:0] coeffs_q;

  logic [FillW-1:0]     fill;
  logic [2*KYBER_COEFF_W-1:0] head_bits;
  logic [4:0]           pair_bits;
  logic [5:0]           word_target;
  logic                 clear, push, pop, accept, ready;
  logic [COEFF_W-1:0]   mask, c0, c1;

  assign pair_bits   = {l_q, 1'b0};
  assign word_target = {l_q, 2'b00};
  assign clear       = (state_q == S_IDLE) && i_start;
  assign accept      = valid_q && i_coeffs_ready;

  assign ready = (state_q == S_RUN) && (fill <= FillW'(BUF_W - WORD_W)) &&
                 (words_q < word_target);
  assign push  = i_ibytes_valid && ready;
  assign pop   = (state_q == S_RUN) && (fill >= {2'b00, pair_bits}) &&
                 (!valid_q || i_coeffs_ready);

  bit_unpacker #(
    .WORD_W (WORD_W),
    .BUF_W  (BUF_W),
    .FILL_W (FillW),
    .SHIFT_W(5)
  ) u_unpack (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_clear   (clear),
    .i_push    (push),
    .i_word    (i_ibytes),
    .i_pop     (pop),
    .i_pop_bits(pair_bits),
    .o_fill    (fill),
    .o_bits    (head_bits)
  );

  always_comb begin
    logic [2*KYBER_COEFF_W-1:0] upper;
    mask  = l_mask(l_q);
    upper = head_bits >> l_q;
    c0    = head_bits[COEFF_W-1:0] & mask;
    c1    = upper[COEFF_W-1:0] & mask;
`ifdef DECODE_MODQ_EN
    if (l_q == L_12) begin
      if (c0 >= COEFF_W'(KYBER_Q)) c0 = c0 - COEFF_W'(KYBER_Q);
      if (c1 >= COEFF_W'(KYBER_Q)) c1 = c1 - COEFF_W'(KYBER_Q);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_start) state_d = S_RUN;
      S_RUN:  if (accept && (pairs_q == 8'(KYBER_N / 2 - 1))) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      l_q      <= L_12;
      words_q  <= '0;
      pairs_q  <= '0;
      valid_q  <= 1'b0;
      coeffs_q <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        l_q     <= sanitize_l(i_l);
        words_q <= '0;
        pairs_q <= '0;
      end else begin
        if (push)   words_q <= words_q + 6'd1;
        if (accept) pairs_q <= pairs_q + 8'd1;
      end
      // Output register only advances on an empty slot or a completed handshake.
      if (pop) begin
        valid_q  <= 1'b1;
        coeffs_q <= {c1, c0};
      end else if (accept) begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign o_ibytes_ready = ready;
  assign o_coeffs       = coeffs_q;
  assign o_coeffs_valid = valid_q;
  assign o_done         = (state_q == S_DONE);

endmodule

// File: tb/tb_byte_decode.sv
// Scoreboard bench for byte_decode: frames are packed from known coefficients and the
// expected pair stream is queued before feeding; DECODE_MODQ_EN selects the expected reduction.
module tb_byte_decode;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_start;
  logic [3:0]  i_l;
  logic [63:0] i_ibytes;
  logic        i_ibytes_valid;
  logic        o_ibytes_ready;
  logic [23:0] o_coeffs;
  logic        o_coeffs_valid;
  logic        i_coeffs_ready;
  logic        o_done;

  always #5 i_clk = ~i_clk;

  byte_decode dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_start       (i_start),
    .i_l           (i_l),
    .i_ibytes      (i_ibytes),
    .i_ibytes_valid(i_ibytes_valid),
    .o_ibytes_ready(o_ibytes_ready),
    .o_coeffs      (o_coeffs),
    .o_coeffs_valid(o_coeffs_valid),
    .i_coeffs_ready(i_coeffs_ready),
    .o_done        (o_done)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] exp_q[$];
  int          coeffs[256];
  logic [63:0] words[48];
  int          words_acc;
  int          pairs_acc;
  bit          abort_f;

  function automatic logic [11:0] model_coeff(input int c, input int l);
    int m;
    m = c & ((1 << l) - 1);
`ifdef DECODE_MODQ_EN
    if (l == 12 && m >= 3329) m = m - 3329;
`endif
    return 12'(m);
  endfunction

  task automatic build_frame(input int l);
    exp_q.delete();
    for (int w = 0; w < 48; w++) words[w] = '0;
    for (int k = 0; k < 256; k++)
      for (int j = 0; j < l; j++) begin
        int b;
        b = k * l + j;
        words[b / 64][b % 64] = 1'((coeffs[k] >> j) & 1);
      end
    for (int k = 0; k < 128; k++)
      exp_q.push_back({model_coeff(coeffs[2*k+1], l), model_coeff(coeffs[2*k], l)});
  endtask

  task automatic do_start(input logic [3:0] l_in);
    @(negedge i_clk);
    i_start = 1'b1;
    i_l     = l_in;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic feeder(input int l, input bit gaps);
    int cycles;
    bit acc;
    cycles = 0;
    for (int w = 0; w < 4 * l; w++) begin
      if (abort_f) break;
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_ibytes_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge i_clk);
      end
      i_ibytes_valid = 1'b1;
      i_ibytes       = words[w];
      acc            = 1'b0;
      while (!acc && !abort_f) begin
        acc = o_ibytes_ready;
        @(posedge i_clk);
        if (acc) words_acc++;
        @(negedge i_clk);
        cycles++;
        if (cycles > 4000) begin
          n_tests++;
          n_fail++;
          $display("FAIL feed_timeout word=%0d actual_accepted=%0d required=%0d", w, words_acc, 4*l);
          abort_f = 1'b1;
        end
      end
    end
    // Offer a surplus word: it must never be taken.
    i_ibytes       = '1;
    i_ibytes_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (abort_f) break;
      n_tests++;
      if (o_ibytes_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL extra_word_ready actual=%b required=0", o_ibytes_ready);
      end
      @(negedge i_clk);
    end
    i_ibytes_valid = 1'b0;
  endtask

  task automatic sink(input int l, input bit rand_ready, input int abort_after);
    int          cycles;
    int          fill;
    bit          rdy, hs, prev_stall;
    logic [23:0] prev_data, exp;
    cycles     = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (pairs_acc < 128) begin
      rdy            = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      i_coeffs_ready = rdy;
      hs             = 1'b0;
      if (prev_stall) begin
        n_tests++;
        if (o_coeffs_valid !== 1'b1 || o_coeffs !== prev_data) begin
          n_fail++;
          $display("FAIL stall_hold actual=%b/%h required=1/%h", o_coeffs_valid, o_coeffs, prev_data);
        end
      end
      fill = words_acc * 64 - 2 * l * (pairs_acc + (o_coeffs_valid ? 1 : 0));
      if (fill > 24) begin
        n_tests++;
        if (o_ibytes_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ready_when_full fill=%0d actual=%b required=0", fill, o_ibytes_ready);
        end
      end
      n_tests++;
      if (o_done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_early pair=%0d actual=%b required=0", pairs_acc, o_done);
      end
      if (o_coeffs_valid === 1'b1 && rdy) begin
        hs = 1'b1;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pair_extra actual=%h required=none", o_coeffs);
        end else begin
          exp = exp_q.pop_front();
          if (o_coeffs !== exp) begin
            n_fail++;
            $display("FAIL pair_%0d l=%0d actual=%h required=%h", pairs_acc, l, o_coeffs, exp);
          end
        end
      end
      prev_stall = (o_coeffs_valid === 1'b1) && !rdy;
      prev_data  = o_coeffs;
      @(posedge i_clk);
      if (hs) pairs_acc++;
      @(negedge i_clk);
      cycles++;
      if (abort_after != 0 && pairs_acc == abort_after) begin
        abort_f = 1'b1;
        return;
      end
      if (cycles > 4000) begin
        n_tests++;
        n_fail++;
        $display("FAIL sink_timeout actual_pairs=%0d required=128", pairs_acc);
        abort_f = 1'b1;
        return;
      end
    end
    n_tests++;
    if (o_done !== 1'b1 || o_coeffs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse actual=%b/%b required=1/0", o_done, o_coeffs_valid);
    end
    @(negedge i_clk);
    n_tests++;
    if (o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width actual=%b required=0", o_done);
    end
  endtask

  task automatic run_frame(input int l, input bit gaps, input bit rand_ready, input int abort_after);
    words_acc = 0;
    pairs_acc = 0;
    abort_f   = 1'b0;
    fork
      feeder(l, gaps);
      sink(l, rand_ready, abort_after);
    join
    i_ibytes_valid = 1'b0;
    i_coeffs_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    n_tests++;
    if (o_coeffs !== '0 || o_coeffs_valid !== 1'b0 || o_ibytes_ready !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s actual=%h/%b/%b/%b required=0/0/0/0", tag, o_coeffs, o_coeffs_valid,
               o_ibytes_ready, o_done);
    end
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_start = 1'b0; i_l = 4'd0; i_ibytes = '0;
    i_ibytes_valid = 1'b0; i_coeffs_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    check_idle_outputs("reset_outputs");
    i_rstn = 1'b1;
    @(negedge i_clk);
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_l1_pattern();
    for (int k = 0; k < 256; k++) coeffs[k] = k & 1;
    build_frame(1);
    do_start(4'd1);
    run_frame(1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_l12_ramp();
    for (int k = 0; k < 256; k++) coeffs[k] = k;
    build_frame(12);
    do_start(4'd12);
    run_frame(12, 1'b0, 1'b0, 0);
  endtask

  task automatic test_l10_stall();
    for (int k = 0; k < 256; k++) coeffs[k] = int'($urandom_range(0, 1023));
    build_frame(10);
    do_start(4'd10);
    run_frame(10, 1'b1, 1'b1, 0);
  endtask

  task automatic test_modq();
    for (int k = 0; k < 256; k++) coeffs[k] = (k < 6) ? 4095 : int'($urandom_range(0, 4095));
    build_frame(12);
    do_start(4'd12);
    run_frame(12, 1'b0, 1'b1, 0);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 256; k++) coeffs[k] = int'($urandom_range(0, 31));
    build_frame(5);
    do_start(4'd5);
    run_frame(5, 1'b0, 1'b0, 10);
    i_rstn = 1'b0;
    #1;
    check_idle_outputs("reset_mid_outputs");
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    check_idle_outputs("reset_mid_idle");
    for (int k = 0; k < 256; k++) coeffs[k] = int'($urandom_range(0, 15));
    build_frame(4);
    do_start(4'd4);
    run_frame(4, 1'b0, 1'b0, 0);
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < 256; k++) coeffs[k] = int'($urandom_range(0, 4095));
    build_frame(12);
    do_start(4'd7);
    do_start(4'd1);
    run_frame(12, 1'b1, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_l1_pattern();
    test_l12_ramp();
    test_l10_stall();
    test_modq();
    test_reset_mid();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
